// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-channel UART transmit arbiter.
// Holds the sequencer states, the channel id type and counter-width helper.
package uart_arb_pkg;

  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 2048;
  localparam int GAP_CYCLES_DEF     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_WAIT,
    ST_GAP
  } arb_state_t;

  typedef logic chan_id_t;

  // Width of a counter that runs 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_arb_chan_buf.sv
// One-entry byte holding register for one arbiter channel.
// Latency: byte visible on buf_data the cycle after the accepting edge.
// Backpressure: wr_ready low while full; emptied only by the free strobe.
module uart_arb_chan_buf
  import uart_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_sis,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              full,
  output logic [DATA_W-1:0] buf_data,
  input  logic              free
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_sis) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (free) begin
      full_q <= 1'b0;
    end else if (wr_valid && !full_q) begin
      full_q <= 1'b1;
      data_q <= wr_data;
    end
  end

  assign wr_ready = !full_q;
  assign full     = full_q;
  assign buf_data = data_q;

endmodule

// File: rtl/uart_link_arbiter.sv
// Round-robin sharing of one UART TX between two byte channels, with watchdog.
// Latency: accept -> tx_start three cycles later on an idle TX; UART_ARB_GAP_EN adds an idle gap per frame.
// Backpressure: per-channel ready drops while its byte is buffered; held in ARM while tx_busy.
module uart_link_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`ifdef UART_ARB_GAP_EN
  ,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF
`endif
) (
  input  logic              clk_sis,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              grant_id,
  output logic              active,
  output logic              timeout_err,
  output logic              err_sticky,
  output logic [7:0]        frame_cnt0,
  output logic [7:0]        frame_cnt1
);

  localparam int WD_W = cnt_w(TIMEOUT_CYCLES);
`ifdef UART_ARB_GAP_EN
  localparam int GAP_W = cnt_w(GAP_CYCLES);
  localparam arb_state_t FRAME_END = ST_GAP;
`else
  localparam arb_state_t FRAME_END = ST_IDLE;
`endif

  arb_state_t        state_q, state_d;
  logic              full0, full1;
  logic [DATA_W-1:0] data0, data1;
  logic              free0, free1;
  logic              load, done_evt, abort_evt;
  chan_id_t          pick, grant_q, last_grant_q;
  logic [WD_W-1:0]   wd_q;
  logic              wd_expired;
  logic [DATA_W-1:0] tx_data_q;
  logic              err_sticky_q;
  logic [7:0]        cnt0_q, cnt1_q;

  uart_arb_chan_buf #(.DATA_W(DATA_W)) u_buf0 (
    .clk_sis  (clk_sis),
    .rst      (rst),
    .wr_valid (req0_valid),
    .wr_data  (req0_data),
    .wr_ready (req0_ready),
    .full     (full0),
    .buf_data (data0),
    .free     (free0)
  );

  uart_arb_chan_buf #(.DATA_W(DATA_W)) u_buf1 (
    .clk_sis  (clk_sis),
    .rst      (rst),
    .wr_valid (req1_valid),
    .wr_data  (req1_data),
    .wr_ready (req1_ready),
    .full     (full1),
    .buf_data (data1),
    .free     (free1)
  );

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

`ifdef UART_ARB_GAP_EN
  logic [GAP_W-1:0] gap_q;

  always_ff @(posedge clk_sis) begin
    if (rst || state_q != ST_GAP) gap_q <= '0;
    else                          gap_q <= gap_q + 1'b1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    done_evt  = 1'b0;
    abort_evt = 1'b0;
    // With both channels waiting, the one not served last goes next.
    pick      = (full0 && full1) ? ~last_grant_q : full1;
    case (state_q)
      ST_IDLE: begin
        if (full0 || full1) begin
          load    = 1'b1;
          state_d = ST_ARM;
        end
      end
      ST_ARM:   if (!tx_busy) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the expiry cycle still counts as a good frame.
        if (tx_done) begin
          done_evt = 1'b1;
          state_d  = FRAME_END;
        end else if (wd_expired) begin
          abort_evt = 1'b1;
          state_d   = FRAME_END;
        end
      end
`ifdef UART_ARB_GAP_EN
      ST_GAP:   if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  assign free0 = (done_evt || abort_evt) && (grant_q == 1'b0);
  assign free1 = (done_evt || abort_evt) && (grant_q == 1'b1);

  always_ff @(posedge clk_sis) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tx_data_q    <= '0;
      wd_q         <= '0;
      err_sticky_q <= 1'b0;
      cnt0_q       <= 8'd0;
      cnt1_q       <= 8'd0;
    end else begin
      state_q <= state_d;
      if (load) begin
        grant_q   <= pick;
        tx_data_q <= pick ? data1 : data0;
      end
      if (state_q == ST_START)     wd_q <= '0;
      else if (state_q == ST_WAIT) wd_q <= wd_q + 1'b1;
      if (done_evt || abort_evt) last_grant_q <= grant_q;
      if (abort_evt) err_sticky_q <= 1'b1;
      if (done_evt) begin
        if (grant_q) cnt1_q <= cnt1_q + 8'd1;
        else         cnt0_q <= cnt0_q + 8'd1;
      end
    end
  end

  assign tx_start    = (state_q == ST_START) && !rst;
  assign timeout_err = abort_evt && !rst;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign active      = (state_q != ST_IDLE);
  assign err_sticky  = err_sticky_q;
  assign frame_cnt0  = cnt0_q;
  assign frame_cnt1  = cnt1_q;

endmodule

// File: doc/uart_link_arbiter.md
# uart_link_arbiter

Shares a single UART transmitter between two byte sources (channel 0 = UART1 path, channel 1 = UART2 path) and sequences each frame. It buffers one byte per channel, selects a channel round-robin, pulses the transmitter start, waits for frame completion (with watchdog), and optionally enforces an inter-frame gap. It sits between the two requesting blocks and the UART TX core in the system clock domain.

## Interface

- DATA_W, 8, byte width of channel data and tx_data
- TIMEOUT_CYCLES, 2048, clk_sis cycles allowed between tx_start and tx_done before abort
- GAP_CYCLES, 16, idle clk_sis cycles inserted after each frame (used only with gap feature)

Ports:
- clk_sis  in  1  system clock; one clock for the whole block
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  channel 0 byte available
- req0_data  in  DATA_W  channel 0 byte
- req0_ready  out  1  channel 0 holding buffer empty
- req1_valid  in  1  channel 1 byte available
- req1_data  in  DATA_W  channel 1 byte
- req1_ready  out  1  channel 1 holding buffer empty
- tx_start  out  1  one-cycle pulse launching a frame
- tx_data  out  DATA_W  byte for the transmitter; stable from ARM through WAIT
- tx_busy  in  1  transmitter occupied
- tx_done  in  1  one-cycle pulse at end of stop bit
- grant_id  out  1  channel owning the transmitter (valid when active=1)
- active  out  1  FSM not in IDLE
- timeout_err  out  1  one-cycle pulse on watchdog abort
- err_sticky  out  1  set on any abort, cleared only by rst
- frame_cnt0  out  8  frames completed for channel 0, wraps 255->0
- frame_cnt1  out  8  frames completed for channel 1, wraps 255->0

## Operation

- Per channel: one-entry buffer; ready = buffer empty; byte captured on edge where valid && ready.
- FSM states: IDLE, ARM, START, WAIT, GAP.
- IDLE: if any buffer full, pick channel; both full -> channel != last_grant; load tx_data, grant_id; go ARM.
- ARM: wait while tx_busy=1; when tx_busy=0 go START.
- START: tx_start=1 for exactly this cycle; go WAIT; watchdog cleared.
- WAIT: on tx_done: free granted buffer, increment its frame_cnt, last_grant <= grant_id, go GAP (or IDLE without gap feature). If watchdog reaches TIMEOUT_CYCLES without tx_done: drop byte, free buffer, frame_cnt unchanged, timeout_err pulse, err_sticky=1, last_grant updated, go GAP/IDLE.
- GAP: count GAP_CYCLES, then IDLE.
- Buffer of the non-granted channel may accept a byte at any time it is empty.
- Buffers are registered: byte accepted on edge E0 is seen by IDLE in the following cycle.

## Timing

- Reset (sync): state IDLE, buffers empty, req0_ready=req1_ready=1, tx_start=0, tx_data=0, grant_id=0, active=0, timeout_err=0, err_sticky=0, frame counters 0, last_grant=1 (channel 0 wins first tie).
- Latency, idle transmitter: accept on E0 -> ARM after E1 -> START after E2 -> tx_start high in cycle between E2 and E3.
- Granted buffer frees on the edge that samples tx_done; its ready is high the next cycle.
- tx_done in same cycle as watchdog expiry: tx_done wins, no error.
- tx_done outside WAIT: ignored.
- Both channels continuously valid: frames strictly alternate 0,1,0,1.
- rst asserted mid-frame: all state returns to reset values on that edge; buffered bytes discarded; tx_start never asserted during rst.
- frame_cnt 255 + done -> 0, no flag.

## Configuration

- UART_ARB_GAP_EN defined: GAP state present; GAP_CYCLES idle cycles after every completed or aborted frame, active=1 during GAP.
- Not defined: GAP state and its counter removed; WAIT returns directly to IDLE; GAP_CYCLES unused.

## Structure

- Package uart_arb_pkg: FSM state enum, channel-id type (1 bit), DATA_W default, TIMEOUT counter width derivation via $clog2.
- Sub-module uart_arb_chan_buf: one-entry holding register (valid/ready in, data out, full flag, free strobe), instantiated twice.

## Test plan

- Single byte: req0 0x5B, tx_busy=0 -> tx_start pulse 3rd cycle after accept, tx_data=0x5B, after tx_done frame_cnt0=1, req0_ready high next cycle.
- Tie: both valid same cycle (0x5B, 0x42) after reset -> channel 0 sent first, then channel 1; grant_id 0 then 1.
- Busy hold-off: tx_busy=1 for 20 cycles while ch1 buffered -> no tx_start until cycle after tx_busy falls.
- Watchdog: withhold tx_done -> timeout_err pulse at TIMEOUT_CYCLES, err_sticky=1, frame_cnt unchanged, buffer freed; done+expiry same cycle -> no error.
- Wrap/gap: 256 frames on ch0 -> frame_cnt0=0; with UART_ARB_GAP_EN, tx_start spacing after tx_done >= GAP_CYCLES+3.
- Reset mid-WAIT: rst for one cycle -> all outputs at reset values next cycle, both ready=1, no stale tx_start.
